// File: rtl/mul_mont.sv
// Bit-serial Montgomery multiplier over the Ed448 (Goldilocks) field.
// result = a * b * 2^-448 mod P, fully reduced, DATA_WIDTH+3 cycles after start.

package parameters_pkg;
  localparam int DATA_WIDTH = 448;
  // P = 2^448 - 2^224 - 1: every bit set except bit 224
  localparam logic [DATA_WIDTH-1:0] P =
    {{(DATA_WIDTH/2-1){1'b1}}, 1'b0, {(DATA_WIDTH/2){1'b1}}};
  // R^2 mod P with R = 2^448; since 2^448 == 2^224 + 1 this is 3*2^224 + 2
  localparam logic [DATA_WIDTH-1:0] R2_MOD_P =
    (DATA_WIDTH'(3) << (DATA_WIDTH/2)) | DATA_WIDTH'(2);
endpackage

module mul_mont
  import parameters_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done
);

  // Two guard bits keep S + b + P (< 4P) from overflowing
  localparam int SW = DATA_WIDTH + 2;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [SW-1:0] P_EXT = {2'b00, P};
  localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_REDUCE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [SW-1:0]         r_s;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_done;

  logic [DATA_WIDTH-1:0] w_b_red;
  logic [SW-1:0]         w_add;
  logic [SW-1:0]         w_odd;
  logic [SW-1:0]         w_red;

  // Operand b may be up to 2^448-1 < 2P, so a single subtraction brings it below P
  assign w_b_red = (r_b >= P) ? (r_b - P) : r_b;

  // One Montgomery step: add a_i*b, make even by adding P, then halve (done at the register)
  assign w_add = r_s + (r_a[0] ? {2'b00, r_b} : '0);
  assign w_odd = w_add + (w_add[0] ? P_EXT : '0);

  // Accumulator ends below 2P, so one conditional subtraction fully reduces it
  assign w_red = (r_s >= P_EXT) ? (r_s - P_EXT) : r_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start is only honoured from IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_LOAD;
      S_LOAD:   w_state_next = S_ITER;
      S_ITER:   if (r_cnt == LAST_ITER) w_state_next = S_REDUCE;
      S_REDUCE: w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, serial accumulation, final reduction and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_s      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a <= a;
            r_b <= b;
          end
        end
        S_LOAD: begin
          r_b   <= w_b_red;
          r_s   <= '0;
          r_cnt <= '0;
        end
        S_ITER: begin
          r_s   <= w_odd >> 1;
          r_a   <= r_a >> 1;
          r_cnt <= r_cnt + CW'(1);
        end
        S_REDUCE: begin
          r_s <= w_red;
        end
        S_DONE: begin
          r_result <= r_s[DATA_WIDTH-1:0];
          r_done   <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign result = r_result;
  assign done   = r_done;

endmodule

// File: tb/tb_mul_mont.sv
// Self-checking bench for mul_mont: directed vectors, random operands against a
// modular-arithmetic reference, and control checks (reset abort, busy/DONE start).
module tb_mul_mont;
  import parameters_pkg::*;

  localparam int W = DATA_WIDTH;
  localparam int LAT = W + 3;

  // R^-1 mod P: R == 2^224 + 1, whose inverse is 2 - 2^224 (mod P)
  localparam logic [W-1:0] RINV = P - (448'd1 << 224) + 448'd2;

  localparam logic [W-1:0] A0   = (448'd1 << 445) - 448'd1;
  localparam logic [W-1:0] ALL1 = {W{1'b1}};
  localparam logic [W-1:0] E1 = (((448'd1 << 222) + 448'd1) << 224)
                              + ((448'd1 << 224) - (448'd1 << 222) - 448'd4);
  localparam logic [W-1:0] E2 = (((448'd3 << 221) + 448'd2) << 224)
                              + ((448'd1 << 224) - (448'd3 << 221) - 448'd6);
  localparam logic [W-1:0] E3 = (((448'd1 << 224) - 448'd2) << 224) + 448'd1;
  localparam logic [W-1:0] ERT = (448'd1 << 446) - (448'd7 << 221) - 448'd1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         done;

  int n_asserts;
  int n_fail;

  mul_mont dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .result (result),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain modular arithmetic, a*b mod P then times R^-1 mod P
  function automatic logic [W-1:0] ref_mont(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] t;
    t = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    t = t % {{W{1'b0}}, P};
    t = t * {{W{1'b0}}, RINV};
    t = t % {{W{1'b0}}, P};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand448();
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < W / 32; k++) r = {r[W-33:0], 32'($urandom())};
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation, measure latency, check the done pulse is a single cycle
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output logic [W-1:0] res);
    int lat;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = rand448();
    b = rand448();
    lat = 0;
    for (int n = 1; n <= LAT + 100; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    res = result;
    check({tag, "_lat"}, W'(lat), W'(LAT));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, W'(done), W'(0));
    $display("op %s a=%h b=%h result=%h latency=%0d", tag, av, bv, res, lat);
  endtask

  initial begin
    logic [W-1:0] res;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] exp_v;
    int           lat;
    int           saw;

    n_asserts = 0;
    n_fail    = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_result", result, '0);
    check("reset_done", W'(done), W'(0));

    // Directed vectors with hand-derived expected values
    run_op("a0_b2", A0, 448'd2, res);
    check("a0_b2_val", res, E1);
    check("a0_b2_model", res, ref_mont(A0, 448'd2));
    run_op("a0_b3", A0, 448'd3, res);
    check("a0_b3_val", res, E2);
    run_op("max_max", ALL1, ALL1 - 448'd1, res);
    check("max_max_val", res, E3);
    run_op("zero_a", '0, ALL1, res);
    check("zero_a_val", res, '0);
    run_op("zero_b", rand448(), '0, res);
    check("zero_b_val", res, '0);

    // Round trip: into Montgomery form and back out
    run_op("to_mont", A0, R2_MOD_P, res);
    check("to_mont_val", res, ERT);
    x = res;
    run_op("from_mont", x, 448'd1, res);
    check("from_mont_val", res, A0);

    // Random operands, some forced to >= P, back to back
    for (int i = 0; i < 8; i++) begin
      x = rand448();
      y = rand448();
      if (i % 3 == 0) x = ALL1 - W'($urandom_range(0, 1000));
      if (i % 4 == 1) y = P + W'($urandom_range(0, 1000));
      run_op($sformatf("rand%0d", i), x, y, res);
      check($sformatf("rand%0d_val", i), res, ref_mont(x, y));
    end

    // Reset during ITER aborts with no done and clears result
    @(negedge clk);
    a = rand448();
    b = rand448();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_result", result, '0);
    saw = 0;
    repeat (LAT + 50) begin
      @(posedge clk);
      #1;
      if (done) saw = 1;
    end
    check("abort_no_done", W'(saw), W'(0));
    $display("op abort_mid_iter done_seen=%0d result=%h", saw, result);

    // start pulsed while busy is ignored
    x = rand448();
    y = rand448();
    exp_v = ref_mont(x, y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= LAT + 100; n++) begin
      @(posedge clk);
      #1;
      if (n == 50) begin
        start = 1'b1;
        a = rand448();
        b = rand448();
      end
      if (n == 51) start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    check("busy_start_lat", W'(lat), W'(LAT));
    check("busy_start_val", result, exp_v);
    $display("op busy_start result=%h latency=%0d", result, lat);

    // start presented in the DONE cycle is ignored
    x = rand448();
    y = rand448();
    exp_v = ref_mont(x, y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= LAT + 100; n++) begin
      @(posedge clk);
      #1;
      if (n == LAT - 1) start = 1'b1;
      if (n == LAT) start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    check("done_start_lat", W'(lat), W'(LAT));
    check("done_start_val", result, exp_v);
    saw = 0;
    repeat (LAT + 10) begin
      @(posedge clk);
      #1;
      if (done) saw = 1;
    end
    check("done_start_ignored", W'(saw), W'(0));
    $display("op done_cycle_start result=%h extra_done=%0d", result, saw);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
